// File: rtl/bp_pkg.sv
// Shared branch-history-table parameters, write-port payload type and
// FSM state encoding for the BHT write arbiter.
package bp_pkg;

    localparam int BHT_ENTRY_W = 20;
    localparam int BHT_SETS    = 16;
    localparam int BHT_WAYS    = 4;
    localparam int BHT_ADDR_W  = 6;
    localparam int SET_W       = $clog2(BHT_SETS);
    localparam int WAY_W       = $clog2(BHT_WAYS);
    localparam int UPDQ_DEPTH  = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    typedef struct packed {
        logic [BHT_ADDR_W-1:0]  addr;
        logic [BHT_ENTRY_W-1:0] data;
    } bht_wr_t;

endpackage

// File: rtl/bht_write_arbiter_if.sv
// Request/response bundle of the BHT write arbiter: global controls, alloc,
// update and invalidate requests, the single write port and status.
interface bht_write_arbiter_if;
    import bp_pkg::*;

    logic                   en;
    logic                   stall;
    logic                   alloc_valid;
    logic [SET_W-1:0]       alloc_set;
    logic [BHT_ENTRY_W-1:0] alloc_data;
    logic                   upd_valid;
    logic [BHT_ADDR_W-1:0]  upd_addr;
    logic [BHT_ENTRY_W-1:0] upd_data;
    logic                   inv_req;
    logic                   inv_busy;
    logic                   inv_done;
    logic                   wr_en;
    logic [BHT_ADDR_W-1:0]  wr_addr;
    logic [BHT_ENTRY_W-1:0] wr_data;
    logic                   upd_drop;
    logic [1:0]             q_count;

    modport slave (
        input  en, stall, alloc_valid, alloc_set, alloc_data,
               upd_valid, upd_addr, upd_data, inv_req,
        output inv_busy, inv_done, wr_en, wr_addr, wr_data, upd_drop, q_count
    );

    modport master (
        output en, stall, alloc_valid, alloc_set, alloc_data,
               upd_valid, upd_addr, upd_data, inv_req,
        input  inv_busy, inv_done, wr_en, wr_addr, wr_data, upd_drop, q_count
    );

endinterface

// File: rtl/bht_upd_queue.sv
// Two-entry merging FIFO for deferred BHT counter updates. Supports dequeue,
// stale-entry delete and merge-or-enqueue in the same cycle; head is slot 0.
module bht_upd_queue
    import bp_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_deq,
    input  logic                  i_del_v,
    input  logic [BHT_ADDR_W-1:0] i_del_addr,
    input  logic                  i_upd_v,
    input  bht_wr_t               i_upd,
    output logic                  o_head_v,
    output bht_wr_t               o_head,
    output logic                  o_del_hit,
    output logic                  o_drop,
    output logic [1:0]            o_count
);

    logic [UPDQ_DEPTH-1:0]   r_v;
    bht_wr_t [UPDQ_DEPTH-1:0] r_ent;

    logic [UPDQ_DEPTH-1:0]   w_keep;
    logic [UPDQ_DEPTH-1:0]   w_v;
    bht_wr_t [UPDQ_DEPTH-1:0] w_ent;

    always_comb begin
        w_keep[0] = r_v[0] & ~i_deq & ~(i_del_v & (r_ent[0].addr == i_del_addr));
        w_keep[1] = r_v[1] & ~(i_del_v & (r_ent[1].addr == i_del_addr));

        // Survivors are compacted toward slot 0 before merge/enqueue.
        w_v   = '0;
        w_ent = r_ent;
        if (w_keep[0]) begin
            w_v[0] = 1'b1;
            w_v[1] = w_keep[1];
        end else if (w_keep[1]) begin
            w_v[0]   = 1'b1;
            w_ent[0] = r_ent[1];
        end

        o_drop = 1'b0;
        if (i_upd_v) begin
            if (w_v[0] && (w_ent[0].addr == i_upd.addr)) begin
                w_ent[0].data = i_upd.data;
            end else if (w_v[1] && (w_ent[1].addr == i_upd.addr)) begin
                w_ent[1].data = i_upd.data;
            end else if (!w_v[0]) begin
                w_v[0]   = 1'b1;
                w_ent[0] = i_upd;
            end else if (!w_v[1]) begin
                w_v[1]   = 1'b1;
                w_ent[1] = i_upd;
            end else begin
                o_drop = 1'b1;
            end
        end

        if (i_clr) begin
            w_v = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v <= '0;
        end else begin
            r_v <= w_v;
        end
    end

    // NOTE: payload registers carry no reset; every read is qualified by r_v,
    // so only the valid bits need a defined value out of reset.
    always_ff @(posedge i_clk) begin
        r_ent <= w_ent;
    end

    assign o_head_v  = r_v[0];
    assign o_head    = r_ent[0];
    assign o_del_hit = i_del_v & ((r_v[0] & (r_ent[0].addr == i_del_addr)) |
                                  (r_v[1] & (r_ent[1].addr == i_del_addr)));
    assign o_count   = {1'b0, r_v[0]} + {1'b0, r_v[1]};

endmodule

// File: rtl/bht_write_arbiter.sv
// Single-port BHT write arbiter: alloc with per-set FIFO replacement, queued
// saturating-counter updates, and a full-table invalidate sweep.
module bht_write_arbiter
    import bp_pkg::*;
(
    input logic                CLK,
    input logic                nrst,
    bht_write_arbiter_if.slave bus
);

    logic [0:0]                 r_state;
    logic [BHT_ADDR_W-1:0]      r_sweep_addr;
    logic [BHT_SETS-1:0][WAY_W-1:0] r_ptr;
    logic                       r_wr_en;
    bht_wr_t                    r_wr;
    logic                       r_inv_done;
    logic                       r_upd_drop;

    logic                  w_idle_go;
    logic                  w_alloc;
    logic                  w_upd;
    logic [BHT_ADDR_W-1:0] w_alloc_addr;
    logic                  w_upd_clash;
    logic                  w_deq;
    logic                  w_head_bypass;
    logic                  w_upd_direct;
    logic                  w_q_upd_v;
    logic                  w_q_clr;
    logic                  w_wr_v;
    bht_wr_t               w_wr;
    logic                  w_drop;

    logic                  w_q_head_v;
    bht_wr_t               w_q_head;
    logic                  w_q_del_hit;
    logic                  w_q_drop;
    logic [1:0]            w_q_count;

    // An invalidate request in IDLE pre-empts everything else that cycle.
    assign w_idle_go     = bus.en & (r_state == ST_IDLE) & ~bus.inv_req;
    assign w_alloc       = w_idle_go & ~bus.stall & bus.alloc_valid;
    assign w_upd         = w_idle_go & ~bus.stall & bus.upd_valid;
    assign w_alloc_addr  = {bus.alloc_set, r_ptr[bus.alloc_set]};
    assign w_upd_clash   = w_alloc & w_upd & (bus.upd_addr == w_alloc_addr);
    assign w_deq         = w_idle_go & ~w_alloc & w_q_head_v;
    assign w_head_bypass = w_deq & w_upd & (bus.upd_addr == w_q_head.addr);
    assign w_upd_direct  = w_upd & ~w_alloc & ~w_q_head_v;
    assign w_q_upd_v     = w_upd & ~w_upd_clash & ~w_head_bypass & ~w_upd_direct;
    assign w_q_clr       = bus.en & (r_state == ST_IDLE) & bus.inv_req;
    assign w_wr_v        = w_alloc | w_deq | w_upd_direct;
    assign w_drop        = w_upd_clash | w_q_drop | w_q_del_hit;

    always_comb begin
        w_wr.addr = bus.upd_addr;
        w_wr.data = bus.upd_data;
        if (w_alloc) begin
            w_wr.addr = w_alloc_addr;
            w_wr.data = bus.alloc_data;
        end else if (w_deq) begin
            // A fresh update to the head address merges on its way out.
            w_wr.addr = w_q_head.addr;
            w_wr.data = w_head_bypass ? bus.upd_data : w_q_head.data;
        end
    end

    bht_upd_queue u_upd_queue (
        .i_clk      (CLK),
        .i_rst_n    (nrst),
        .i_clr      (w_q_clr),
        .i_deq      (w_deq),
        .i_del_v    (w_alloc),
        .i_del_addr (w_alloc_addr),
        .i_upd_v    (w_q_upd_v),
        .i_upd      ('{addr: bus.upd_addr, data: bus.upd_data}),
        .o_head_v   (w_q_head_v),
        .o_head     (w_q_head),
        .o_del_hit  (w_q_del_hit),
        .o_drop     (w_q_drop),
        .o_count    (w_q_count)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_sweep_addr <= '0;
            r_ptr        <= '0;
            r_wr_en      <= 1'b0;
            r_wr         <= '0;
            r_inv_done   <= 1'b0;
            r_upd_drop   <= 1'b0;
        end else begin
            r_wr_en    <= 1'b0;
            r_inv_done <= 1'b0;
            r_upd_drop <= 1'b0;
            if (bus.en) begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.inv_req) begin
                            r_state      <= ST_SWEEP;
                            r_sweep_addr <= '0;
                        end else begin
                            r_upd_drop <= w_drop;
                            if (w_wr_v) begin
                                r_wr_en <= 1'b1;
                                r_wr    <= w_wr;
                            end
                            if (w_alloc) begin
                                r_ptr[bus.alloc_set] <= r_ptr[bus.alloc_set] + 2'd1;
                            end
                        end
                    end
                    ST_SWEEP: begin
                        r_wr_en      <= 1'b1;
                        r_wr.addr    <= r_sweep_addr;
                        r_wr.data    <= '0;
                        r_sweep_addr <= r_sweep_addr + 6'd1;
                        if (r_sweep_addr == '1) begin
                            r_state    <= ST_IDLE;
                            r_inv_done <= 1'b1;
                            r_ptr      <= '0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.inv_busy = (r_state == ST_SWEEP);
    assign bus.inv_done = r_inv_done;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr.addr;
    assign bus.wr_data  = r_wr.data;
    assign bus.upd_drop = r_upd_drop;
    assign bus.q_count  = w_q_count;

endmodule
